cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Multicycle FSM controller for the 16-bit datapath (register file, ALU, data memory, 2:1 writeback mux).
//  Owns the PC and the IR. Fetches from instruction memory, decodes, and drives every datapath control:
//  RF addresses/enables, ALU select, data-memory address/write, and the writeback mux select RF_s.
// PARAMETERS
//  PC_W    7   instruction-memory address width; PC wraps 2^PC_W-1 -> 0
//  DADDR_W 8   data-memory address width
//  RFA_W   4   register-file address width (16 regs)
// PORTS
//  Clk        in   1       rising-edge clock
//  ResetN     in   1       asynchronous, active-low reset
//  Run        in   1       1 = execute; 0 = hold in FETCH (no fetch, no PC change)
//  InstrData  in   16      ROM[PC], combinational; valid whenever PC is stable
//  PC         out  PC_W    program counter (registered)
//  IR         out  16      instruction register (registered)
//  D_Addr     out  DADDR_W data-memory address
//  D_Wr       out  1       data-memory write enable
//  RF_s       out  1       writeback mux select: 0 = ALU result, 1 = memory read data
//  RF_W_en    out  1       register-file write enable
//  RF_W_addr  out  RFA_W   register-file write address
//  RF_Ra_addr out  RFA_W   register-file read port A address
//  RF_Rb_addr out  RFA_W   register-file read port B address
//  ALU_s      out  3       000 pass A, 001 A+B, 010 A-B
//  Halted     out  1       1 while in HALT
// BEHAVIOUR
//  Reset (ResetN=0, async): state=INIT, PC=0, IR=0. Every output is 0. Reset mid-instruction aborts it;
//   no D_Wr/RF_W_en pulse is emitted after ResetN falls.
//  Encoding: op=IR[15:12].
//   NOOP=0000.
//   STORE=0001: M[IR[11:4]] <= R[IR[3:0]].
//   LOAD=0010: R[IR[3:0]] <= M[IR[11:4]].
//   ADD=0011 / SUB=0100: R[IR[3:0]] <= R[IR[11:8]] +/- R[IR[7:4]].
//   HALT=0101. Opcodes 0110-1111 execute as NOOP.
//  States and transitions, one cycle each:
//   INIT -> FETCH.
//   FETCH: if Run, IR<=InstrData, PC<=PC+1 (mod 2^PC_W) -> DECODE. Otherwise stay; PC and IR held.
//   DECODE: select on op -> NOOP | STORE | LOAD_A | ADD | SUB | HALT.
//   NOOP -> FETCH.
//   STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_Wr=1 -> FETCH.
//   LOAD_A: D_Addr=IR[11:4] (sync memory read issued) -> LOAD_B.
//   LOAD_B: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1 -> FETCH.
//   ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], ALU_s=001/010, RF_s=0, RF_W_addr=IR[3:0],
//    RF_W_en=1 -> FETCH.
//   HALT: Halted=1; terminal; only ResetN exits. Run is ignored.
//  Outputs are Moore (state + IR). Anything not listed for a state is 0. No glitching enables.
//  Latency per instruction, including FETCH and DECODE: NOOP/STORE/ADD/SUB 3 clk, LOAD 4 clk, HALT 2 clk to Halted.
//  At most one of D_Wr and RF_W_en is high in any cycle.
//  RF_s=1 only in LOAD_B.
//  Run deasserted outside FETCH: the current instruction completes, then the FSM parks in FETCH.
// STRUCTURE
//  Shared package cpu_pkg:
//   opcode_t enum (NOOP..HALT)
//   state_t enum (INIT, FETCH, DECODE, NOOP, STORE, LOAD_A, LOAD_B, ADD, SUB, HALT)
//   ALU_PASS/ALU_ADD/ALU_SUB constants
//  Sub-module program_counter: PC_W bits, async active-low clear, Up increment with wrap.
//  FSM and IR register stay in cpu_controller.
// TESTING
//  1 Reset: ResetN=0 mid-STORE -> D_Wr falls immediately; PC=0, IR=0, all outputs 0; INIT->FETCH after release.
//  2 InstrData=16'h2_1B_3 (LOAD) -> D_Addr=8'h1B on 2 cycles; only LOAD_B has RF_s=1, RF_W_addr=3, RF_W_en=1; PC +1.
//  3 16'h1_1C_5 (STORE) -> one D_Wr pulse with D_Addr=8'h1C, RF_Ra_addr=5; RF_W_en stays 0.
//  4 16'h3_12_4 (ADD) then 16'h4_12_4 (SUB) -> Ra=1, Rb=2, W_addr=4, ALU_s=001 then 010, RF_s=0; 3 clk each.
//  5 PC=7'h7F, Run=1 -> PC=0 after FETCH. Run=0 in FETCH for 5 clk -> PC and IR unchanged.
//  6 16'h5000 (HALT) -> Halted=1 two clk after FETCH; stays through 20 clk of Run toggling; 16'hF000 acts as NOOP.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle controller: opcodes, FSM states, ALU selects.
package cpu_pkg;
  localparam int PC_W    = 7;
  localparam int DADDR_W = 8;
  localparam int RFA_W   = 4;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_HALT  = 4'b0101
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_NOOP, S_STORE,
    S_LOAD_A, S_LOAD_B, S_ADD, S_SUB, S_HALT
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
endpackage

// File: rtl/cpu_controller_program_counter.sv
// Program counter: async active-low clear, increments on up and wraps at 2^W.
module program_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (up) count <= count + W'(1);
  end
endmodule

// File: rtl/cpu_controller.sv
// Multicycle FSM controller: owns PC and IR, sequences fetch/decode/execute and drives datapath controls.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int DADDR_W = cpu_pkg::DADDR_W,
  parameter int RFA_W   = cpu_pkg::RFA_W
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Run,
  input  logic [15:0]        InstrData,
  output logic [PC_W-1:0]    PC,
  output logic [15:0]        IR,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic               RF_W_en,
  output logic [RFA_W-1:0]   RF_W_addr,
  output logic [RFA_W-1:0]   RF_Ra_addr,
  output logic [RFA_W-1:0]   RF_Rb_addr,
  output logic [2:0]         ALU_s,
  output logic               Halted
);
  state_t state, state_nx;
  logic   fetch;

  assign fetch = (state == S_FETCH) && Run;

  program_counter #(.W(PC_W)) u_pc (
    .clk   (Clk),
    .rst_n (ResetN),
    .up    (fetch),
    .count (PC)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= S_INIT;
      IR    <= '0;
    end else begin
      state <= state_nx;
      if (fetch) IR <= InstrData;
    end
  end

  // Outputs depend only on state and IR, so enables cannot glitch on input changes.
  always_comb begin
    state_nx   = state;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = ALU_PASS;
    Halted     = 1'b0;
    case (state)
      S_INIT:  state_nx = S_FETCH;
      S_FETCH: if (Run) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode_t'(IR[15:12]))
          OP_STORE: state_nx = S_STORE;
          OP_LOAD:  state_nx = S_LOAD_A;
          OP_ADD:   state_nx = S_ADD;
          OP_SUB:   state_nx = S_SUB;
          OP_HALT:  state_nx = S_HALT;
          default:  state_nx = S_NOOP;
        endcase
      end
      S_NOOP: state_nx = S_FETCH;
      S_STORE: begin
        D_Addr     = DADDR_W'(IR[11:4]);
        RF_Ra_addr = RFA_W'(IR[3:0]);
        D_Wr       = 1'b1;
        state_nx   = S_FETCH;
      end
      S_LOAD_A: begin
        D_Addr   = DADDR_W'(IR[11:4]);
        state_nx = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_Addr    = DADDR_W'(IR[11:4]);
        RF_s      = 1'b1;
        RF_W_addr = RFA_W'(IR[3:0]);
        RF_W_en   = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RFA_W'(IR[11:8]);
        RF_Rb_addr = RFA_W'(IR[7:4]);
        ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr  = RFA_W'(IR[3:0]);
        RF_W_en    = 1'b1;
        state_nx   = S_FETCH;
      end
      S_HALT: Halted = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench: instruction-level reference model expands each fetched instruction into its expected control cycles.
module tb_cpu_controller;
  logic        Clk = 1'b0;
  logic        ResetN, Run;
  logic [15:0] InstrData;
  logic [6:0]  PC;
  logic [15:0] IR;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0]  ALU_s;

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic       w_en;
    logic [3:0] w_addr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } ctl_t;

  logic [15:0] rom [128];
  ctl_t        exp_q[$];
  int          pc_m;
  logic [15:0] ir_m;
  bit          halted_m, init_m;
  int          n_chk = 0, n_pass = 0;

  always #5 Clk = ~Clk;
  assign InstrData = rom[PC];

  cpu_controller dut (
    .Clk(Clk), .ResetN(ResetN), .Run(Run), .InstrData(InstrData),
    .PC(PC), .IR(IR), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s(ALU_s), .Halted(Halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op = 4'($urandom_range(0, 15));
    if (op == 4'd5) op = 4'd3;
    return {op, 12'($urandom)};
  endfunction

  // Expected per-cycle controls after the fetch edge: DECODE is always idle, then the op's execute cycles.
  task automatic model_fetch();
    ctl_t c = '0;
    ir_m = rom[pc_m];
    pc_m = (pc_m + 1) % 128;
    exp_q.push_back('0);
    case (ir_m[15:12])
      4'h1: begin c.d_addr = ir_m[11:4]; c.ra = ir_m[3:0]; c.d_wr = 1; exp_q.push_back(c); end
      4'h2: begin
        c.d_addr = ir_m[11:4]; exp_q.push_back(c);
        c.rf_s = 1; c.w_addr = ir_m[3:0]; c.w_en = 1; exp_q.push_back(c);
      end
      4'h3, 4'h4: begin
        c.ra = ir_m[11:8]; c.rb = ir_m[7:4]; c.w_addr = ir_m[3:0]; c.w_en = 1;
        c.alu = (ir_m[15:12] == 4'h3) ? 3'b001 : 3'b010;
        exp_q.push_back(c);
      end
      4'h5: halted_m = 1;
      4'h0: ;
      default: exp_q.push_back('0);
    endcase
    if (ir_m[15:12] == 4'h0) exp_q.push_back('0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pc_m = 0; ir_m = '0; halted_m = 0; init_m = 1;
  endtask

  task automatic check_outputs(input string tag);
    ctl_t obs, e;
    obs = {D_Addr, D_Wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s};
    e = (init_m || exp_q.size() == 0) ? ctl_t'('0) : exp_q[0];
    chk({tag, "_ctl"}, 32'(obs), 32'(e));
    chk({tag, "_pc"}, 32'(PC), 32'(pc_m));
    chk({tag, "_ir"}, 32'(IR), 32'(ir_m));
    chk({tag, "_halted"}, 32'(Halted), 32'(halted_m && !init_m && exp_q.size() == 0));
    if (D_Wr && RF_W_en) chk({tag, "_excl"}, 32'(2), 32'(1));
  endtask

  task automatic step(input bit run_v, input string tag);
    Run = run_v;
    @(posedge Clk);
    if (ResetN) begin
      if (init_m)                init_m = 0;
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (!halted_m && run_v) model_fetch();
    end
    @(negedge Clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    ResetN = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    step(1, tag);
    step(1, tag);
    #2 ResetN = 1'b1;
    step(0, {tag, "_init"});
  endtask

  initial begin
    bit found;
    ResetN = 1'b0; Run = 1'b0;
    rom[0] = 16'h21B3; rom[1] = 16'h11C5; rom[2] = 16'h3124;
    rom[3] = 16'h4124; rom[4] = 16'hF000; rom[5] = 16'h0000;
    for (int i = 6; i < 128; i++) rom[i] = rand_instr();
    model_reset();
    #3;
    do_reset("rst0");
    for (int i = 0; i < 5; i++) step(0, "stall");
    for (int i = 0; i < 16; i++) step(1, "directed");
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0, "rand");

    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step(1, "seek_store");
      found = exp_q.size() > 0 && exp_q[0].d_wr;
    end
    chk("store_seen", 32'(found), 32'(1));
    #2;
    do_reset("rst_mid_store");

    for (int i = 0; i < 8; i++) rom[i] = rand_instr();
    rom[8] = 16'h5000;
    #2 ResetN = 1'b0;
    do_reset("rst_halt");
    for (int i = 0; i < 60; i++) step($urandom_range(0, 1) != 0, "halt_phase");
    chk("halt_end", 32'(Halted), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
